// File: rtl/ppheavy_pkg.sv
// ppheavy_pkg: shared state encoding and default widths for the prepolarization pulse sequencer
package ppheavy_pkg;
  localparam int ON_W_DEF = 16;
  localparam int DT_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD1 = 3'd1,
    ON    = 3'd2,
    DEAD2 = 3'd3,
    DIS   = 3'd4
  } state_t;
endpackage

// File: rtl/ppheavy_tick_cnt.sv
// ppheavy_tick_cnt: loadable down-counter that holds at zero, with zero and reaching-zero flags
import ppheavy_pkg::*;
module ppheavy_tick_cnt #(
  parameter int ON_W = ON_W_DEF
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [ON_W-1:0] val,
  output logic            zero,
  output logic            hit
);
  logic [ON_W-1:0] cnt;
  // load wins over counting; an enabled count stops at zero instead of wrapping
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
  assign hit  = en && cnt == ON_W'(1);
endmodule

// File: rtl/ppheavy_pulse_seq.sv
// ppheavy_pulse_seq: break-before-make prepolarization sequence (dead, on, dead, discharge, done)
import ppheavy_pkg::*;
module ppheavy_pulse_seq #(
  parameter int ON_W = ON_W_DEF,
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            start,
  input  logic            tick_10k,
  input  logic            abort,
  input  logic [ON_W-1:0] on_time,
  input  logic [ON_W-1:0] dis_time,
  input  logic [DT_W-1:0] dead_time,
  output logic            pp_sw_on,
  output logic            pp_dis_on,
  output logic            busy,
  output logic            done,
  output logic            err_overlap
);
  state_t          state, nxt;
  logic [ON_W-1:0] on_lat, dis_lat, t_val;
  logic [DT_W-1:0] dt_lat, d_val;
  logic            t_load, d_load, t_zero, t_hit, d_zero, d_hit, d_end, t_end;
  // dead phase ends on its last counted cycle; a zero load ends it after one cycle
  assign d_end = d_hit || d_zero;
  assign d_val = (state == IDLE) ? dead_time : dt_lat;
  // tick count after this edge is zero: DIS then becomes the done cycle with the switch off
  assign t_end = t_load ? (t_val == '0) : (t_zero || t_hit);
  ppheavy_tick_cnt #(.ON_W(ON_W)) u_tick (
    .clk_sys(clk_sys), .rst(rst), .load(t_load), .en(tick_10k),
    .val(t_val), .zero(t_zero), .hit(t_hit)
  );
  ppheavy_tick_cnt #(.ON_W(DT_W)) u_dead (
    .clk_sys(clk_sys), .rst(rst), .load(d_load), .en(1'b1),
    .val(d_val), .zero(d_zero), .hit(d_hit)
  );
  // next state and counter loads; abort in DEAD1 goes to a zero-length DIS so done still pulses
  always_comb begin
    nxt    = state;
    t_load = 1'b0;
    t_val  = on_lat;
    d_load = 1'b0;
    case (state)
      IDLE:
        if (start && !abort) begin
          nxt    = DEAD1;
          d_load = 1'b1;
        end
      DEAD1:
        if (abort) begin
          nxt    = DIS;
          t_load = 1'b1;
          t_val  = '0;
        end else if (d_end && on_lat == '0) begin
          nxt    = DEAD2;
          d_load = 1'b1;
        end else if (d_end) begin
          nxt    = ON;
          t_load = 1'b1;
        end
      ON:
        if (abort || t_hit) begin
          nxt    = DEAD2;
          d_load = 1'b1;
        end
      DEAD2:
        if (d_end) begin
          nxt    = DIS;
          t_load = 1'b1;
          t_val  = dis_lat;
        end
      DIS:     nxt = t_zero ? IDLE : DIS;
      default: nxt = IDLE;
    endcase
  end
  // state and registered outputs, all derived from the next state
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      state       <= IDLE;
      pp_sw_on    <= 1'b0;
      pp_dis_on   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      state       <= nxt;
      pp_sw_on    <= nxt == ON;
      pp_dis_on   <= nxt == DIS && !t_end;
      done        <= nxt == DIS && t_end;
      busy        <= nxt != IDLE;
      err_overlap <= err_overlap || (start && state != IDLE);
    end
  // configuration captured on an accepted start so later changes do not disturb the run
  always_ff @(posedge clk_sys or posedge rst)
    if (rst) begin
      on_lat  <= '0;
      dis_lat <= '0;
      dt_lat  <= '0;
    end else if (state == IDLE && start && !abort) begin
      on_lat  <= on_time;
      dis_lat <= dis_time;
      dt_lat  <= dead_time;
    end
endmodule

// File: tb/tb_ppheavy_pulse_seq.sv
// tb_ppheavy_pulse_seq: randomized episodes checked against an interval-based timeline model
module tb_ppheavy_pulse_seq;
  localparam int N = 512;
  logic clk_sys = 1'b0, rst = 1'b1, start = 1'b0, tick_10k = 1'b0, abort = 1'b0;
  logic [15:0] on_time = '0, dis_time = '0;
  logic [7:0] dead_time = '0;
  logic pp_sw_on, pp_dis_on, busy, done, err_overlap;
  int n_chk = 0, n_pass = 0, ep = 0;
  bit errv = 1'b0;
  bit e_sw[N], e_dis[N], e_busy[N], e_done[N], e_err[N], tk[N];

  always #5 clk_sys = ~clk_sys;

  ppheavy_pulse_seq dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .tick_10k(tick_10k), .abort(abort),
    .on_time(on_time), .dis_time(dis_time), .dead_time(dead_time),
    .pp_sw_on(pp_sw_on), .pp_dis_on(pp_dis_on), .busy(busy), .done(done),
    .err_overlap(err_overlap)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sw"}, pp_sw_on, 1'b0);
    chk({tag, " dis"}, pp_dis_on, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " err"}, err_overlap, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk_sys);
    rst = 1'b0;
    errv = 1'b0;
  endtask

  // expected timeline: dead gaps of max(dt,1) cycles, on/dis windows end on the n-th tick seen inside them
  task automatic run_ep(input int dt, on, dis, p, ph, s, a, s2, r);
    int m, fin, g, q, e, f, cnt, len;
    string t;
    m = (dt == 0) ? 1 : dt;
    for (int c = 0; c < N; c++) begin
      e_sw[c] = 0; e_dis[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      tk[c] = (c % p) == ph;
    end
    fin = -1;
    if (a != s) begin
      if (a > s && a <= s + m) fin = a + 1;
      else begin
        g = s + m + 1;
        if (on > 0) begin
          cnt = 0;
          for (e = g; e < N - 1; e++) begin
            if (tk[e]) cnt++;
            if (cnt == on || e == a) break;
          end
          for (int c = g; c <= e; c++) e_sw[c] = 1;
          g = e + 1;
        end
        q = g + m;
        if (dis == 0) fin = q;
        else begin
          cnt = 0;
          for (f = q; f < N - 1; f++) begin
            if (tk[f]) cnt++;
            if (cnt == dis) break;
          end
          for (int c = q; c <= f; c++) e_dis[c] = 1;
          fin = f + 1;
        end
      end
      for (int c = s + 1; c <= fin; c++) e_busy[c] = 1;
      e_done[fin] = 1;
    end
    len = (fin < 0) ? s + 8 : fin + 5;
    if (len > N) len = N;
    if (s2 == -2) s2 = (fin < 0) ? -1 : s + 1 + int'($urandom_range(fin - s - 1));
    for (int c = 0; c < N; c++) begin
      e_err[c] = errv || (s2 >= 0 && c > s2);
      if (r >= 0 && c > r) begin
        e_sw[c] = 0; e_dis[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
      end
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk_sys);
      t = $sformatf("ep%0d c%0d", ep, c);
      chk({t, " sw"}, pp_sw_on, e_sw[c]);
      chk({t, " dis"}, pp_dis_on, e_dis[c]);
      chk({t, " busy"}, busy, e_busy[c]);
      chk({t, " done"}, done, e_done[c]);
      chk({t, " err"}, err_overlap, e_err[c]);
      chk({t, " overlap"}, pp_sw_on & pp_dis_on, 1'b0);
      if (c == r + 1) rst = 1'b0;
      start = (c == s) || (c == s2);
      abort = (c == a);
      tick_10k = tk[c];
      if (c == s) begin
        on_time = 16'(on); dis_time = 16'(dis); dead_time = 8'(dt);
      end else begin
        on_time = 16'($urandom); dis_time = 16'($urandom); dead_time = 8'($urandom);
      end
      if (c == r) begin
        rst = 1'b1;
        #1 chk_zero({t, " async rst"});
      end
    end
    start = 1'b0; abort = 1'b0; tick_10k = 1'b0;
    errv = (r >= 0) ? 1'b0 : (errv || s2 >= 0);
    ep++;
  endtask

  initial begin
    int dt, on, dis, p, ph, s, a, s2, k;
    repeat (2) @(negedge clk_sys);
    chk_zero("initial");
    rst = 1'b0;
    run_ep(3, 5, 2, 10, 0, 20, -1, -1, -1);
    run_ep(2, 0, 4, 7, 3, 5, -1, -1, -1);
    run_ep(0, 3, 3, 4, 1, 5, -1, -1, -1);
    run_ep(3, 5, 2, 10, 0, 20, 41, -1, -1);
    run_ep(3, 5, 2, 10, 0, 20, -1, 85, -1);
    run_ep(3, 5, 2, 10, 0, 20, -1, 22, 50);
    run_ep(3, 5, 2, 10, 0, 5, -1, -1, -1);
    run_ep(0, 0, 0, 3, 0, 4, -1, -1, -1);
    run_ep(2, 4, 3, 5, 0, 6, 6, -1, -1);
    run_ep(0, 2, 0, 1, 0, 3, -1, -2, -1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) do_reset();
      dt  = int'($urandom_range(5));
      on  = int'($urandom_range(6));
      dis = int'($urandom_range(6));
      p   = 1 + int'($urandom_range(11));
      ph  = int'($urandom_range(p - 1));
      s   = 2 + int'($urandom_range(4));
      k   = int'($urandom_range(7));
      a   = (k == 0) ? s : (k < 4) ? s + int'($urandom_range(80)) : -1;
      s2  = ($urandom_range(2) == 0) ? -2 : -1;
      run_ep(dt, on, dis, p, ph, s, a, s2, -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
